// File: rtl/axi4_read_slave_pkg.sv
// Shared AXI read-path types: response codes, read FSM states and the 4KB burst boundary.
package axi_enum_packet;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DATA
  } rd_state_e;

  localparam int BOUNDARY_4K = 4096;

endpackage

// File: rtl/axi4_read_slave_sram.sv
// DEPTH x WIDTH memory: one write port for preload, one synchronous read port.
// A read and write of the same word on the same edge returns the old contents.
module axi4_sram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi4_read_slave.sv
// AXI4 read slave (AR + R channels) serving one INCR burst at a time from axi4_sram.
//   state | meaning
//   IDLE  | ARREADY high, waiting for an address
//   FETCH | reading the current beat's word (skipped on error)
//   DATA  | RVALID high, beat held until RREADY
module axi4_read_slave
  import axi_enum_packet::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 1024
) (
  input  logic                            aclk_i,
  input  logic                            aresetn_i,
  input  logic [ADDR_WIDTH-1:0]           araddr_i,
  input  logic [7:0]                      arlen_i,
  input  logic [2:0]                      arsize_i,
  input  logic                            arvalid_i,
  output logic                            arready_o,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  output logic [1:0]                      rresp_o,
  output logic                            rlast_o,
  output logic                            rvalid_o,
  input  logic                            rready_i,
  input  logic                            mem_we_i,
  input  logic [$clog2(MEMORY_DEPTH)-1:0] mem_waddr_i,
  input  logic [DATA_WIDTH-1:0]           mem_wdata_i
);

  localparam int LSB = $clog2(DATA_WIDTH / 8);
  localparam int WA  = ADDR_WIDTH + 9;
  localparam int MW  = $clog2(MEMORY_DEPTH);

  rd_state_e     state_q;
  logic [WA-1:0] addr_q;
  logic [7:0]    len_q;
  logic [7:0]    beat_q;
  logic [2:0]    size_q;
  logic          err_q;
  logic          arready_q;
  logic          rvalid_q;
  logic          rlast_q;
  resp_e         rresp_q;

  logic [WA-1:0]         start_d;
  logic [WA-1:0]         span_d;
  logic [WA-1:0]         last_d;
  logic                  err_d;
  logic                  sram_re;
  logic [MW-1:0]         sram_raddr;
  logic [DATA_WIDTH-1:0] sram_rdata;

  // Burst checks run on the raw AR inputs, widened so no term can wrap.
  always_comb begin
    start_d = WA'(araddr_i);
    span_d  = WA'({1'b0, arlen_i} + 9'd1) << arsize_i;
    last_d  = start_d + (WA'(arlen_i) << arsize_i);
    err_d   = (arsize_i > 3'(LSB))
            | ((WA'(araddr_i[11:0]) + span_d) > WA'(BOUNDARY_4K))
            | ((last_d >> LSB) >= WA'(MEMORY_DEPTH));
  end

  assign sram_re    = (state_q == ST_FETCH) && !err_q;
  assign sram_raddr = MW'(addr_q >> LSB);

  axi4_sram #(
    .DEPTH (MEMORY_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_sram (
    .clk_i   (aclk_i),
    .we_i    (mem_we_i),
    .waddr_i (mem_waddr_i),
    .wdata_i (mem_wdata_i),
    .re_i    (sram_re),
    .raddr_i (sram_raddr),
    .rdata_o (sram_rdata)
  );

  always_ff @(posedge aclk_i) begin
    if (!aresetn_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      size_q    <= '0;
      err_q     <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          arready_q <= 1'b1;
          if (arvalid_i && arready_q) begin
            addr_q    <= start_d;
            len_q     <= arlen_i;
            size_q    <= arsize_i;
            beat_q    <= '0;
            err_q     <= err_d;
            rresp_q   <= err_d ? RESP_SLVERR : RESP_OKAY;
            arready_q <= 1'b0;
            state_q   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          rvalid_q <= 1'b1;
          rlast_q  <= (beat_q == len_q);
          state_q  <= ST_DATA;
        end
        ST_DATA: begin
          if (rready_i) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (rlast_q) begin
              arready_q <= 1'b1;
              state_q   <= ST_IDLE;
            end else begin
              beat_q  <= beat_q + 8'd1;
              addr_q  <= addr_q + (WA'(1) << size_q);
              state_q <= ST_FETCH;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign arready_o = arready_q;
  assign rvalid_o  = rvalid_q;
  assign rlast_o   = rlast_q;
  assign rresp_o   = rresp_q;
  // Error bursts and idle cycles present zero data.
  assign rdata_o   = (rvalid_q && !err_q) ? sram_rdata : '0;

endmodule

// File: tb/tb_axi4_read_slave.sv
// Self-checking bench for axi4_read_slave: table bursts, random bursts, reset and same-edge preload cases.
module tb_axi4_read_slave;

  localparam int DEPTH = 1024;
  localparam int LSB   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        mem_we;
  logic [9:0]  mem_waddr;
  logic [31:0] mem_wdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem_m [DEPTH];

  always #5 clk = ~clk;

  axi4_read_slave #(
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (16),
    .MEMORY_DEPTH (DEPTH)
  ) dut (
    .aclk_i      (clk),
    .aresetn_i   (rst_n),
    .araddr_i    (araddr),
    .arlen_i     (arlen),
    .arsize_i    (arsize),
    .arvalid_i   (arvalid),
    .arready_o   (arready),
    .rdata_o     (rdata),
    .rresp_o     (rresp),
    .rlast_o     (rlast),
    .rvalid_o    (rvalid),
    .rready_i    (rready),
    .mem_we_i    (mem_we),
    .mem_waddr_i (mem_waddr),
    .mem_wdata_i (mem_wdata)
  );

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    int          mode;
    bit          err;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out", nm);
  endtask

  // Reference rules: byte address per beat, 4KB window, memory range, bus width.
  function automatic bit model_err(input int a, input int l, input int s);
    int nbytes;
    int last;
    nbytes = (l + 1) * (1 << s);
    last   = a + l * (1 << s);
    return (s > LSB) || ((a % 4096) + nbytes > 4096) || ((last / 4) >= DEPTH);
  endfunction

  task automatic preload(input int w, input logic [31:0] d);
    mem_we    = 1'b1;
    mem_waddr = 10'(w);
    mem_wdata = d;
    @(negedge clk);
    mem_we    = 1'b0;
    mem_m[w]  = d;
  endtask

  // mode: 0 RREADY held high, 1 pattern 0,1,0,0,1, 2 random.
  // abort_after >= 0 returns right after that many beats have been accepted.
  // wr_fetch overwrites the first beat's word on the same edge that reads it.
  task automatic run_burst(input int id, input logic [15:0] a, input logic [7:0] l,
                           input logic [2:0] s, input int mode, input bit exp_err,
                           input int abort_after, input bit wr_fetch);
    logic [31:0] exp_d [256];
    int          beat;
    int          cyc;
    int          p;
    int          w;
    bit          pat [5];
    pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i <= int'(l); i++) begin
      w = (int'(a) + i * (1 << int'(s))) / 4;
      exp_d[i] = (exp_err || w >= DEPTH) ? 32'h0 : mem_m[w];
    end
    araddr  = a;
    arlen   = l;
    arsize  = s;
    arvalid = 1'b1;
    rready  = 1'b0;
    cyc = 0;
    while (!arready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!arready) begin
      timeout_fail($sformatf("t%0d_arready", id));
      arvalid = 1'b0;
      return;
    end
    @(negedge clk);
    arvalid = 1'b0;
    check($sformatf("t%0d_arready_low", id), 32'(arready), 32'h0);
    check($sformatf("t%0d_lat_fetch_rvalid", id), 32'(rvalid), 32'h0);
    if (wr_fetch) begin
      mem_we    = 1'b1;
      mem_waddr = 10'(int'(a) / 4);
      mem_wdata = ~mem_m[int'(a) / 4];
    end
    @(negedge clk);
    if (wr_fetch) begin
      mem_we = 1'b0;
      mem_m[int'(a) / 4] = mem_wdata;
    end
    check($sformatf("t%0d_lat_first_rvalid", id), 32'(rvalid), 32'h1);
    beat = 0;
    cyc  = 0;
    p    = 0;
    while (beat <= int'(l) && cyc < 4000) begin
      if (beat == abort_after) begin
        rready = 1'b0;
        return;
      end
      case (mode)
        0:       rready = 1'b1;
        1:       rready = pat[p % 5];
        default: rready = 1'($urandom_range(0, 1));
      endcase
      p++;
      if (rvalid) begin
        check($sformatf("t%0d_b%0d_rdata", id, beat), rdata, exp_d[beat]);
        check($sformatf("t%0d_b%0d_rresp", id, beat), 32'(rresp), exp_err ? 32'h2 : 32'h0);
        check($sformatf("t%0d_b%0d_rlast", id, beat), 32'(rlast), 32'(beat == int'(l)));
        if (rready) beat++;
      end
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    if (beat <= int'(l)) begin
      timeout_fail($sformatf("t%0d_beats", id));
      return;
    end
    check($sformatf("t%0d_end_rvalid", id), 32'(rvalid), 32'h0);
    check($sformatf("t%0d_end_arready", id), 32'(arready), 32'h1);
  endtask

  initial begin
    vec_t tbl [11];
    logic [15:0] ra;
    logic [7:0]  rl;
    logic [2:0]  rs;

    tbl[0]  = '{16'h0000, 8'd3,   3'd2, 0, 1'b0};
    tbl[1]  = '{16'h0FF8, 8'd3,   3'd2, 0, 1'b1};
    tbl[2]  = '{16'h0FF0, 8'd7,   3'd2, 0, 1'b1};
    tbl[3]  = '{16'h0FF0, 8'd3,   3'd2, 0, 1'b0};
    tbl[4]  = '{16'h0000, 8'd0,   3'd3, 0, 1'b1};
    tbl[5]  = '{16'h0010, 8'd2,   3'd2, 1, 1'b0};
    tbl[6]  = '{16'h1000, 8'd0,   3'd2, 0, 1'b1};
    tbl[7]  = '{16'h0FFE, 8'd0,   3'd2, 1, 1'b1};
    tbl[8]  = '{16'h0001, 8'd4,   3'd0, 2, 1'b0};
    tbl[9]  = '{16'h0006, 8'd3,   3'd1, 1, 1'b0};
    tbl[10] = '{16'h0C00, 8'd255, 3'd2, 2, 1'b0};

    rst_n = 1'b0; araddr = '0; arlen = '0; arsize = '0; arvalid = 1'b0;
    rready = 1'b0; mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_arready", 32'(arready), 32'h0);
    check("reset_rvalid", 32'(rvalid), 32'h0);
    check("reset_rlast", 32'(rlast), 32'h0);
    check("reset_rresp", 32'(rresp), 32'h0);
    check("reset_rdata", rdata, 32'h0);

    for (int i = 0; i < DEPTH; i++)
      preload(i, (i < 4) ? (32'hA0A0_0000 + 32'(i)) : $urandom);

    rst_n = 1'b1;
    @(negedge clk);
    check("release_arready", 32'(arready), 32'h1);

    for (int i = 0; i < 11; i++)
      run_burst(i, tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].mode, tbl[i].err, -1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom_range(0, 16'h1100));
      rl = 8'($urandom_range(0, 12));
      rs = 3'($urandom_range(0, 3));
      run_burst(100 + i, ra, rl, rs, 2, model_err(int'(ra), int'(rl), int'(rs)), -1, 1'b0);
    end

    // Same-edge preload and read: first burst sees old data, second sees new.
    run_burst(200, 16'h0080, 8'd0, 3'd2, 0, 1'b0, -1, 1'b1);
    run_burst(201, 16'h0080, 8'd0, 3'd2, 0, 1'b0, -1, 1'b0);

    // Reset mid-burst after two beats accepted.
    run_burst(300, 16'h0000, 8'd3, 3'd2, 0, 1'b0, 2, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_rvalid", 32'(rvalid), 32'h0);
    check("midrst_arready", 32'(arready), 32'h0);
    check("midrst_rlast", 32'(rlast), 32'h0);
    @(negedge clk);
    check("midrst_arready_back", 32'(arready), 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("midrst_quiet%0d", i), 32'(rvalid), 32'h0);
    end
    run_burst(301, 16'h0040, 8'd3, 3'd2, 1, 1'b0, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
